// File: rtl/audio_pkg.sv
// Shared definitions for the codec audio path.
//   - mode encodings for i2s_stream_port.mode (2'b11 behaves as mute)
//   - serial-port run state
//   - params_ok(): legality of an i2s_stream_port parameter set
package audio_pkg;

    localparam logic [1:0] MODE_TX   = 2'b00;
    localparam logic [1:0] MODE_LOOP = 2'b01;
    localparam logic [1:0] MODE_MUTE = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } port_state_e;

    // Sample must fit in a slot with one leading BCLK for the Philips delay;
    // the FIFO relies on natural pointer wrap, hence a power-of-two depth.
    function automatic bit params_ok(int sample_w, int slot_w, int bclk_div, int fifo_depth);
        return (sample_w >= 8) && (sample_w <= 32) &&
               (slot_w >= sample_w + 1) &&
               (bclk_div >= 2) &&
               (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO for TX sample pairs.
//   clk, reset (async, active low)
//   push/din  : write when not full (push on full is ignored)
//   pop/dout  : dout shows the head word; pop when not empty advances it
//   full/empty: registered flags, valid the cycle after the causing push/pop
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;
    assign cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Storage needs no reset: empty_q guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/i2s_stream_port.sv
// Parametrised I2S master (Philips format) for the codec path.
//   clk, reset (async, active low), enable (low = idle, pins held at 0)
//   mode           : 00 TX from FIFO, 01 loopback of last captured pair, 1x mute
//   tx_data/valid  : {left, right} pair into the TX FIFO; tx_ready = FIFO not full
//   rx_data/valid  : last captured {left, right}; rx_valid is a one-clk strobe
//   underrun       : sticky, TX frame started with an empty FIFO; clear_underrun clears
//   BCLK, DAC_LR_CLK, ADC_LR_CLK, DAC_DATA : codec pins, all registered
//   ADC_DATA       : serial capture input, sampled on BCLK rise
module i2s_stream_port
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [2*SAMPLE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [2*SAMPLE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    input  logic                  clear_underrun,
    output logic                  BCLK,
    output logic                  DAC_LR_CLK,
    output logic                  ADC_LR_CLK,
    output logic                  DAC_DATA,
    input  logic                  ADC_DATA
);

    localparam int PAIR_W = 2 * SAMPLE_W;
    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam int B_W    = $clog2(2 * SLOT_W);

    if (!params_ok(SAMPLE_W, SLOT_W, BCLK_DIV, FIFO_DEPTH)) begin : g_param_check
        $error("i2s_stream_port: illegal parameter set");
    end

    port_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [B_W-1:0]    b_q;
    logic              bclk_q, lr_q, dac_q;
    logic [PAIR_W-1:0] tx_sh_q;
    logic [PAIR_W-2:0] cap_q;
    logic [PAIR_W-1:0] rx_data_q;
    logic              rx_valid_q, underrun_q;

    logic              div_tc, running, rise, fall, b_last, frame_start;
    logic [B_W-1:0]    b_next, k_cur, k_nxt;
    logic              slot_cur, slot_nxt, data_cur, data_nxt;
    logic [PAIR_W-1:0] load_val;
    logic              fifo_pop, fifo_full, fifo_empty, set_ur;
    logic [PAIR_W-1:0] fifo_dout;

    audio_sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid && !fifo_full),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
    end

    // Divider events and bit/slot bookkeeping. slot = 1 means right channel.
    always_comb begin
        running  = (state_q == ST_RUN) && enable;
        div_tc   = (div_q == DIV_W'(BCLK_DIV - 1));
        rise     = running && div_tc && !bclk_q;
        fall     = running && div_tc && bclk_q;
        b_last   = (b_q == B_W'(2 * SLOT_W - 1));
        b_next   = b_last ? '0 : b_q + B_W'(1);
        slot_cur = (b_q >= B_W'(SLOT_W));
        k_cur    = slot_cur ? b_q - B_W'(SLOT_W) : b_q;
        slot_nxt = (b_next >= B_W'(SLOT_W));
        k_nxt    = slot_nxt ? b_next - B_W'(SLOT_W) : b_next;
        data_cur = (k_cur != '0) && (k_cur <= B_W'(SAMPLE_W));
        data_nxt = (k_nxt != '0) && (k_nxt <= B_W'(SAMPLE_W));
        // The first enabled clk after idle also counts as a frame start.
        frame_start = (enable && (state_q == ST_IDLE)) || (fall && b_last);
    end

    // Frame-start source select; mode is only looked at here, so a mid-frame
    // mode change waits for the next frame.
    always_comb begin
        load_val = '0;
        fifo_pop = 1'b0;
        set_ur   = 1'b0;
        if (frame_start) begin
            case (mode)
                MODE_TX: begin
                    if (!fifo_empty) begin
                        load_val = fifo_dout;
                        fifo_pop = 1'b1;
                    end else begin
                        set_ur = 1'b1;
                    end
                end
                MODE_LOOP: load_val = rx_data_q;
                default:   load_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= '0;
            b_q        <= '0;
            bclk_q     <= 1'b0;
            lr_q       <= 1'b0;
            dac_q      <= 1'b0;
            tx_sh_q    <= '0;
            cap_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!enable) begin
                div_q  <= '0;
                b_q    <= '0;
                bclk_q <= 1'b0;
                lr_q   <= 1'b0;
                dac_q  <= 1'b0;
                cap_q  <= '0;
            end else if (state_q == ST_IDLE) begin
                // Divider holds at 0 this clk so the first rise lands BCLK_DIV clk later.
                tx_sh_q <= load_val;
            end else begin
                div_q <= div_tc ? '0 : div_q + DIV_W'(1);
                if (div_tc) bclk_q <= ~bclk_q;

                // Left bits shift in first, so after the last right bit the
                // register plus the incoming bit is exactly {left, right}.
                if (rise && data_cur) begin
                    cap_q <= {cap_q[PAIR_W-3:0], ADC_DATA};
                    if (slot_cur && (k_cur == B_W'(SAMPLE_W))) begin
                        rx_data_q  <= {cap_q, ADC_DATA};
                        rx_valid_q <= 1'b1;
                    end
                end

                // Same trick on TX: left MSB-first, then right MSB-first out of one register.
                if (fall) begin
                    b_q  <= b_next;
                    lr_q <= slot_nxt;
                    if (data_nxt) begin
                        dac_q   <= tx_sh_q[PAIR_W-1];
                        tx_sh_q <= {tx_sh_q[PAIR_W-2:0], 1'b0};
                    end else begin
                        dac_q <= 1'b0;
                    end
                    if (frame_start) tx_sh_q <= load_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              underrun_q <= 1'b0;
        else if (set_ur)         underrun_q <= 1'b1;
        else if (clear_underrun) underrun_q <= 1'b0;
    end

    assign tx_ready   = ~fifo_full;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign underrun   = underrun_q;
    assign BCLK       = bclk_q;
    assign DAC_LR_CLK = lr_q;
    assign ADC_LR_CLK = lr_q;
    assign DAC_DATA   = dac_q;

endmodule

// File: tb/tb_i2s_stream_port.sv
// Bench for i2s_stream_port (SAMPLE_W 16, SLOT_W 32, BCLK_DIV 2, FIFO_DEPTH 4).
// Model: time since enable (e) gives every pin by division; FIFO is a queue.
module tb_i2s_stream_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        underrun;
    logic        clear_underrun = 1'b0;
    logic        BCLK, DAC_LR_CLK, ADC_LR_CLK, DAC_DATA;
    logic        ADC_DATA = 1'b0;

    i2s_stream_port #(
        .SAMPLE_W(16), .SLOT_W(32), .BCLK_DIV(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun),
        .clear_underrun(clear_underrun), .BCLK(BCLK),
        .DAC_LR_CLK(DAC_LR_CLK), .ADC_LR_CLK(ADC_LR_CLK),
        .DAC_DATA(DAC_DATA), .ADC_DATA(ADC_DATA)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          e = -1;          // clk edges since enable first seen high; -1 = idle
    bit [31:0]   m_fifo[$];
    logic [31:0] m_cur = '0, m_rx = '0;
    logic [31:0] adc_pair = 32'h1234FEDC;
    logic        m_ur = 1'b0, m_rxv = 1'b0, m_ready = 1'b1;
    logic        x_bclk = 1'b0, x_lr = 1'b0, x_dac = 1'b0;
    bit          push_now, ur_set;
    int          mb, mk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e = -1; m_fifo.delete(); m_cur = '0; m_rx = '0;
            m_ur = 1'b0; m_rxv = 1'b0; m_ready = 1'b1;
        end else begin
            push_now = tx_valid && m_ready;
            ur_set = 1'b0;
            m_rxv = 1'b0;
            if (!enable) e = -1;
            else begin
                e = e + 1;
                if (e % 256 == 0) begin
                    if (mode == 2'b00) begin
                        if (m_fifo.size() > 0) m_cur = m_fifo.pop_front();
                        else begin m_cur = '0; ur_set = 1'b1; end
                    end else if (mode == 2'b01) m_cur = m_rx;
                    else m_cur = '0;
                end
                if (e % 256 == 194) begin m_rx = adc_pair; m_rxv = 1'b1; end
            end
            if (ur_set) m_ur = 1'b1;
            else if (clear_underrun) m_ur = 1'b0;
            if (push_now) m_fifo.push_back(tx_data);
            m_ready = (m_fifo.size() < 4);
        end
        if (e < 0) begin
            x_bclk = 1'b0; x_lr = 1'b0; x_dac = 1'b0;
        end else begin
            x_bclk = ((e / 2) % 2) == 1;
            mb = (e / 4) % 64;
            mk = mb % 32;
            x_lr = (mb >= 32);
            if (mk >= 1 && mk <= 16) x_dac = (mb < 32) ? m_cur[32-mk] : m_cur[16-mk];
            else x_dac = 1'b0;
        end
    end

    // ADC stimulus: I2S framing of adc_pair, padding bits driven 1 (must be ignored).
    int ab, ak;
    always @(negedge clk) begin
        if (e < 0) ADC_DATA = 1'b0;
        else begin
            ab = (e / 4) % 64;
            ak = ab % 32;
            if (ak >= 1 && ak <= 16) ADC_DATA = (ab < 32) ? adc_pair[32-ak] : adc_pair[16-ak];
            else ADC_DATA = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("bclk",     32'(BCLK),       32'(x_bclk));
        chk("dac_lr",   32'(DAC_LR_CLK), 32'(x_lr));
        chk("adc_lr",   32'(ADC_LR_CLK), 32'(x_lr));
        chk("dac_data", 32'(DAC_DATA),   32'(x_dac));
        chk("rx_valid", 32'(rx_valid),   32'(m_rxv));
        chk("rx_data",  rx_data,         m_rx);
        chk("tx_ready", 32'(tx_ready),   32'(m_ready));
        chk("underrun", 32'(underrun),   32'(m_ur));
    end

    // ---------------- directed stimulus ----------------
    task automatic run_frame(output logic [31:0] w, output int lr_hi, output int ones,
                             output int rxv, output logic rdy0);
        int ph, bb, kk;
        w = '0; lr_hi = 0; ones = 0; rxv = 0; rdy0 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ph = e % 256; bb = ph / 4; kk = bb % 32;
            if (ph % 4 == 2 && kk >= 1 && kk <= 16) w = {w[30:0], DAC_DATA};
            lr_hi += 32'(DAC_LR_CLK);
            ones  += 32'(DAC_DATA);
            rxv   += 32'(rx_valid);
            if (ph == 0) rdy0 = tx_ready;
        end
    endtask

    task automatic wait_phase(input int ph);
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (e >= 0 && e % 256 == ph) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_phase_timeout", 32'(found), 32'd1);
    endtask

    logic [31:0] pairs [5] = '{32'h11112222, 32'h33334444, 32'h55556666,
                               32'h77778888, 32'h9999AAAA};

    initial begin
        logic [31:0] w;
        int lr_hi, ones, rxv, cnt;
        logic rdy;

        repeat (5) @(negedge clk);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_bclk", 32'(BCLK), 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        reset = 1'b1;

        // idle with enable low
        repeat (1000) @(negedge clk);
        chk("idle_bclk", 32'(BCLK), 32'd0);
        chk("idle_lr", 32'(DAC_LR_CLK), 32'd0);
        chk("idle_underrun", 32'(underrun), 32'd0);
        chk("idle_tx_ready", 32'(tx_ready), 32'd1);

        // TX of one buffered pair
        tx_data = 32'hA5C30F0F; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; enable = 1'b1;
        run_frame(w, lr_hi, ones, rxv, rdy);
        chk("tx_word", w, 32'hA5C30F0F);
        chk("lr_high_clks", 32'(lr_hi), 32'd128);
        chk("rx_valid_per_frame", 32'(rxv), 32'd1);
        chk("underrun_frame0", 32'(underrun), 32'd0);
        chk("rx_word", rx_data, 32'h1234FEDC);

        // empty FIFO -> silence and underrun; clear loses to set
        run_frame(w, lr_hi, ones, rxv, rdy);
        chk("empty_dac_ones", 32'(ones), 32'd0);
        chk("underrun_set", 32'(underrun), 32'd1);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        chk("clear_vs_set", 32'(underrun), 32'd1);
        repeat (7) @(negedge clk);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        chk("clear_underrun", 32'(underrun), 32'd0);

        // loopback takes effect at the next frame start
        mode = 2'b01;
        wait_phase(255);
        run_frame(w, lr_hi, ones, rxv, rdy);
        chk("loop_word", w, 32'h1234FEDC);
        chk("loop_underrun", 32'(underrun), 32'd0);

        // fill FIFO while idle, then drain in order
        enable = 1'b0; mode = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tx_data = pairs[i]; tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("tx_ready_full", 32'(tx_ready), 32'd0);
        enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            run_frame(w, lr_hi, ones, rxv, rdy);
            chk("fifo_order", w, pairs[f]);
            if (f == 0) chk("tx_ready_after_pop", 32'(rdy), 32'd1);
        end
        chk("fifo_underrun", 32'(underrun), 32'd0);

        // enable drop at b = 40
        wait_phase(160);
        chk("lr_at_b40", 32'(DAC_LR_CLK), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_bclk", 32'(BCLK), 32'd0);
        chk("dis_lr", 32'(DAC_LR_CLK), 32'd0);
        chk("dis_adc_lr", 32'(ADC_LR_CLK), 32'd0);
        chk("dis_dac", 32'(DAC_DATA), 32'd0);
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            cnt += 32'(rx_valid);
        end
        chk("aborted_rx_valid", 32'(cnt), 32'd0);

        // async reset at b = 40
        enable = 1'b1;
        wait_phase(160);
        chk("underrun_before_reset", 32'(underrun), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_lr", 32'(DAC_LR_CLK), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        chk("arst_rx_data", rx_data, 32'd0);
        chk("arst_tx_ready", 32'(tx_ready), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
